// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 control unit and datapath: state encoding,
// opcodes and the mux/ALU select encodings both sides must agree on.
package slc3_pkg;

    typedef enum logic [4:0] {
        HALTED = 5'd0,
        S18    = 5'd1,
        S33    = 5'd2,
        S35    = 5'd3,
        S32    = 5'd4,
        S01    = 5'd5,
        S05    = 5'd6,
        S09    = 5'd7,
        S00    = 5'd8,
        S22    = 5'd9,
        S12    = 5'd10,
        S04    = 5'd11,
        S21    = 5'd12,
        S06    = 5'd13,
        S07    = 5'd14,
        S25    = 5'd15,
        S27    = 5'd16,
        S23    = 5'd17,
        S16    = 5'd18,
        PAUSE1 = 5'd19,
        PAUSE2 = 5'd20
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    // States whose dwell time is set by the memory wait timer.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S33) || (s == S25) || (s == S16);
    endfunction

endpackage

// File: rtl/slc3_control_if.sv
// Control-to-datapath bundle: IR fields and BEN in, every load/gate/select and
// the memory enables out, plus the FSM state for observation.
interface slc3_control_if;
    import slc3_pkg::*;

    // Run/Continue are level inputs sampled on the rising clock edge; there is
    // no valid/ready handshake, the control outputs are valid every cycle.
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       SR2MUX, ADDR1MUX, DRMUX, SR1MUX;
    logic       MARMUX, MIO_EN;
    logic [1:0] PCMUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE, Mem_WE;
    state_t     state_dbg;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN,
        output PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, state_dbg
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN,
        input  PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, state_dbg
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable 3-bit down-counter that paces memory accesses; done is high while
// the count is zero, i.e. in the last cycle of a wait.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam logic [2:0] LOAD_VAL = 3'(MEM_WAIT - 1);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 3'd0);

endmodule

// File: rtl/slc3_control.sv
// SLC-3 sequencer: Moore FSM for fetch/decode/execute that drives every
// datapath strobe, bus gate, mux select and memory enable.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    slc3_control_if.master ctl
);

    state_t state_q;
    state_t state_d;
    logic   tmr_load;
    logic   tmr_done;
    logic   unused_ir11;

    // Opcode 0100 always decodes as JSR, so IR[11] never affects sequencing.
    assign unused_ir11 = ctl.IR_11;

    // Reload the timer on the edge that enters a wait state, not while holding.
    assign tmr_load = is_mem_wait_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (tmr_load),
        .done  (tmr_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED: if (ctl.Run) state_d = S18;
            S18:    state_d = S33;
            S33:    if (tmr_done) state_d = S35;
            S35:    state_d = S32;
            S32: begin
                unique case (ctl.Opcode)
                    OP_ADD:   state_d = S01;
                    OP_AND:   state_d = S05;
                    OP_NOT:   state_d = S09;
                    OP_BR:    state_d = S00;
                    OP_JMP:   state_d = S12;
                    OP_JSR:   state_d = S04;
                    OP_LDR:   state_d = S06;
                    OP_STR:   state_d = S07;
                    OP_PAUSE: state_d = PAUSE1;
                    default:  state_d = S18;
                endcase
            end
            S00:    state_d = ctl.BEN ? S22 : S18;
            S04:    state_d = S21;
            S06:    state_d = S25;
            S07:    state_d = S23;
            S25:    if (tmr_done) state_d = S27;
            S23:    state_d = S16;
            S16:    if (tmr_done) state_d = S18;
            PAUSE1: if (ctl.Continue) state_d = PAUSE2;
            // Wait for release so one long press cannot clear several pauses.
            PAUSE2: if (!ctl.Continue) state_d = S18;
            S01, S05, S09, S22, S12, S21, S27: state_d = S18;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        ctl.LD_MAR     = 1'b0;
        ctl.LD_MDR     = 1'b0;
        ctl.LD_IR      = 1'b0;
        ctl.LD_BEN     = 1'b0;
        ctl.LD_CC      = 1'b0;
        ctl.LD_REG     = 1'b0;
        ctl.LD_PC      = 1'b0;
        ctl.LD_LED     = 1'b0;
        ctl.GatePC     = 1'b0;
        ctl.GateMDR    = 1'b0;
        ctl.GateALU    = 1'b0;
        ctl.GateMARMUX = 1'b0;
        ctl.SR2MUX     = 1'b0;
        ctl.ADDR1MUX   = 1'b0;
        ctl.DRMUX      = 1'b0;
        ctl.SR1MUX     = 1'b0;
        ctl.MARMUX     = 1'b0;
        ctl.MIO_EN     = 1'b0;
        ctl.PCMUX      = PCMUX_INC;
        ctl.ADDR2MUX   = ADDR2_ZERO;
        ctl.ALUK       = ALUK_ADD;
        ctl.Mem_OE     = 1'b1;
        ctl.Mem_WE     = 1'b1;
        unique case (state_q)
            S18: begin
                ctl.GatePC = 1'b1;
                ctl.LD_MAR = 1'b1;
                ctl.PCMUX  = PCMUX_INC;
                ctl.LD_PC  = 1'b1;
            end
            S33, S25: begin
                ctl.Mem_OE = 1'b0;
                ctl.MIO_EN = 1'b1;
                ctl.LD_MDR = tmr_done;
            end
            S35: begin
                ctl.GateMDR = 1'b1;
                ctl.LD_IR   = 1'b1;
            end
            S32: ctl.LD_BEN = 1'b1;
            S01, S05: begin
                ctl.SR1MUX  = 1'b1;
                ctl.SR2MUX  = ~ctl.IR_5;
                ctl.ALUK    = (state_q == S01) ? ALUK_ADD : ALUK_AND;
                ctl.GateALU = 1'b1;
                ctl.DRMUX   = 1'b0;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
            end
            S09: begin
                ctl.SR1MUX  = 1'b1;
                ctl.ALUK    = ALUK_NOT;
                ctl.GateALU = 1'b1;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
            end
            S22, S21: begin
                ctl.ADDR1MUX = 1'b0;
                ctl.ADDR2MUX = (state_q == S22) ? ADDR2_OFF9 : ADDR2_OFF11;
                ctl.PCMUX    = PCMUX_ADDER;
                ctl.LD_PC    = 1'b1;
            end
            S12: begin
                ctl.SR1MUX  = 1'b1;
                ctl.ALUK    = ALUK_PASS;
                ctl.GateALU = 1'b1;
                ctl.PCMUX   = PCMUX_BUS;
                ctl.LD_PC   = 1'b1;
            end
            S04: begin
                ctl.GatePC = 1'b1;
                ctl.DRMUX  = 1'b1;
                ctl.LD_REG = 1'b1;
            end
            S06, S07: begin
                ctl.SR1MUX     = 1'b1;
                ctl.ADDR1MUX   = 1'b1;
                ctl.ADDR2MUX   = ADDR2_OFF6;
                ctl.MARMUX     = 1'b0;
                ctl.GateMARMUX = 1'b1;
                ctl.LD_MAR     = 1'b1;
            end
            S27: begin
                ctl.GateMDR = 1'b1;
                ctl.DRMUX   = 1'b0;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
            end
            S23: begin
                ctl.SR1MUX  = 1'b0;
                ctl.ALUK    = ALUK_PASS;
                ctl.GateALU = 1'b1;
                ctl.MIO_EN  = 1'b0;
                ctl.LD_MDR  = 1'b1;
            end
            S16:    ctl.Mem_WE = 1'b0;
            PAUSE1: ctl.LD_LED = 1'b1;
            default: begin
            end
        endcase
    end

    assign ctl.state_dbg = state_q;

endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control with MEM_WAIT=2: walks each instruction
// class through fetch/decode/execute and checks states and control outputs.
module tb_slc3_control;
    import slc3_pkg::*;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    slc3_control_if ctl ();

    slc3_control #(
        .MEM_WAIT (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .ctl   (ctl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [23:0] all_ctrl();
        return {ctl.LD_MAR, ctl.LD_MDR, ctl.LD_IR, ctl.LD_BEN, ctl.LD_CC, ctl.LD_REG,
                ctl.LD_PC, ctl.LD_LED, ctl.GatePC, ctl.GateMDR, ctl.GateALU, ctl.GateMARMUX,
                ctl.SR2MUX, ctl.ADDR1MUX, ctl.DRMUX, ctl.SR1MUX, ctl.MARMUX, ctl.MIO_EN,
                ctl.PCMUX, ctl.ADDR2MUX, ctl.ALUK};
    endfunction

    // From S18 with the opcode presented: S33, S33, S35, then S32.
    task automatic fetch(input logic [3:0] op);
        ctl.Opcode = op;
        tick();
        tick();
        tick();
        tick();
        check("fetch_s32", 32'(ctl.state_dbg), 32'(S32));
    endtask

    always @(negedge Clk) begin
        checks++;
        assert ($onehot0({ctl.GatePC, ctl.GateMDR, ctl.GateALU, ctl.GateMARMUX})
                && !(ctl.Mem_OE == 1'b0 && ctl.Mem_WE == 1'b0)) else begin
            failures++;
            $error("FAIL bus_invariant observed=%b%b%b%b oe=%b we=%b expected=onehot0",
                   ctl.GatePC, ctl.GateMDR, ctl.GateALU, ctl.GateMARMUX, ctl.Mem_OE, ctl.Mem_WE);
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        Reset        = 1'b0;
        ctl.Run      = 1'b0;
        ctl.Continue = 1'b0;
        ctl.Opcode   = 4'b0000;
        ctl.IR_5     = 1'b0;
        ctl.IR_11    = 1'b0;
        ctl.BEN      = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(ctl.state_dbg), 32'(HALTED));
        check("rst_ctrl", 32'(all_ctrl()), 32'h0);
        check("rst_mem", 32'({ctl.Mem_OE, ctl.Mem_WE}), 32'b11);
        Reset = 1'b1;
        tick();
        tick();
        check("halt_hold", 32'(ctl.state_dbg), 32'(HALTED));

        // ADD, immediate form
        ctl.Run    = 1'b1;
        ctl.Opcode = OP_ADD;
        ctl.IR_5   = 1'b1;
        tick();
        ctl.Run = 1'b0;
        check("s18_state", 32'(ctl.state_dbg), 32'(S18));
        check("s18_ctrl", 32'({ctl.GatePC, ctl.LD_MAR, ctl.LD_PC, ctl.PCMUX}), 32'b11100);
        tick();
        check("s33a_state", 32'(ctl.state_dbg), 32'(S33));
        check("s33a_ctrl", 32'({ctl.Mem_OE, ctl.MIO_EN, ctl.LD_MDR}), 32'b010);
        tick();
        check("s33b_state", 32'(ctl.state_dbg), 32'(S33));
        check("s33b_ctrl", 32'({ctl.Mem_OE, ctl.MIO_EN, ctl.LD_MDR}), 32'b011);
        tick();
        check("s35_state", 32'(ctl.state_dbg), 32'(S35));
        check("s35_ctrl", 32'({ctl.GateMDR, ctl.LD_IR}), 32'b11);
        tick();
        check("s32_state", 32'(ctl.state_dbg), 32'(S32));
        check("s32_ldben", 32'(ctl.LD_BEN), 32'd1);
        tick();
        check("s01_state", 32'(ctl.state_dbg), 32'(S01));
        check("s01_ctrl", 32'({ctl.SR2MUX, ctl.GateALU, ctl.LD_REG, ctl.LD_CC, ctl.SR1MUX, ctl.ALUK}),
              32'b0111100);
        ctl.IR_5 = 1'b0;
        #1;
        check("s01_sr2mux_reg", 32'(ctl.SR2MUX), 32'd1);
        tick();
        check("add_back_s18", 32'(ctl.state_dbg), 32'(S18));

        // BR taken, then not taken
        ctl.BEN = 1'b1;
        fetch(OP_BR);
        tick();
        check("br_s00", 32'(ctl.state_dbg), 32'(S00));
        tick();
        check("br_s22", 32'(ctl.state_dbg), 32'(S22));
        check("s22_ctrl", 32'({ctl.PCMUX, ctl.ADDR2MUX, ctl.ADDR1MUX, ctl.LD_PC}), 32'b101001);
        tick();
        check("br_taken_s18", 32'(ctl.state_dbg), 32'(S18));
        ctl.BEN = 1'b0;
        fetch(OP_BR);
        tick();
        check("brn_s00", 32'(ctl.state_dbg), 32'(S00));
        tick();
        check("brn_s18", 32'(ctl.state_dbg), 32'(S18));

        // STR
        fetch(OP_STR);
        tick();
        check("s07_state", 32'(ctl.state_dbg), 32'(S07));
        check("s07_ctrl", 32'({ctl.GateMARMUX, ctl.ADDR2MUX, ctl.ADDR1MUX, ctl.SR1MUX, ctl.LD_MAR}),
              32'b101111);
        tick();
        check("s23_state", 32'(ctl.state_dbg), 32'(S23));
        check("s23_ctrl", 32'({ctl.MIO_EN, ctl.LD_MDR, ctl.GateALU, ctl.ALUK, ctl.SR1MUX}), 32'b011110);
        tick();
        check("s16a", 32'({ctl.state_dbg, ctl.Mem_WE, ctl.Mem_OE}), 32'({S16, 2'b01}));
        tick();
        check("s16b", 32'({ctl.state_dbg, ctl.Mem_WE, ctl.Mem_OE}), 32'({S16, 2'b01}));
        tick();
        check("str_s18", 32'({ctl.state_dbg, ctl.Mem_WE}), 32'({S18, 1'b1}));

        // LDR
        fetch(OP_LDR);
        tick();
        check("s06_state", 32'(ctl.state_dbg), 32'(S06));
        tick();
        check("s25a", 32'({ctl.state_dbg, ctl.Mem_OE, ctl.LD_MDR}), 32'({S25, 2'b00}));
        tick();
        check("s25b", 32'({ctl.state_dbg, ctl.Mem_OE, ctl.LD_MDR}), 32'({S25, 2'b01}));
        tick();
        check("s27", 32'({ctl.state_dbg, ctl.GateMDR, ctl.LD_REG, ctl.LD_CC}), 32'({S27, 3'b111}));
        tick();

        // JSR
        fetch(OP_JSR);
        tick();
        check("s04", 32'({ctl.state_dbg, ctl.GatePC, ctl.DRMUX, ctl.LD_REG}), 32'({S04, 3'b111}));
        tick();
        check("s21", 32'({ctl.state_dbg, ctl.ADDR2MUX, ctl.PCMUX, ctl.LD_PC}), 32'({S21, 5'b11101}));
        tick();
        check("jsr_s18", 32'(ctl.state_dbg), 32'(S18));

        // PAUSE with Continue held for five edges
        fetch(OP_PAUSE);
        tick();
        check("pause1", 32'({ctl.state_dbg, ctl.LD_LED}), 32'({PAUSE1, 1'b1}));
        ctl.Continue = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause2_hold", 32'({ctl.state_dbg, ctl.LD_LED}), 32'({PAUSE2, 1'b0}));
        end
        ctl.Continue = 1'b0;
        tick();
        check("pause_s18", 32'(ctl.state_dbg), 32'(S18));

        // Unsupported opcode behaves as NOP
        fetch(4'b1111);
        check("nop_s32_quiet", 32'({ctl.LD_REG, ctl.LD_PC, ctl.Mem_WE}), 32'b001);
        tick();
        check("nop_s18", 32'(ctl.state_dbg), 32'(S18));

        // Reset asserted in the middle of a write
        fetch(OP_STR);
        tick();
        tick();
        tick();
        check("pre_rst_s16", 32'({ctl.state_dbg, ctl.Mem_WE}), 32'({S16, 1'b0}));
        Reset = 1'b0;
        #1;
        check("midrst_mem", 32'({ctl.Mem_OE, ctl.Mem_WE}), 32'b11);
        check("midrst_ctrl", 32'(all_ctrl()), 32'h0);
        check("midrst_state", 32'(ctl.state_dbg), 32'(HALTED));
        tick();
        Reset = 1'b1;
        tick();
        tick();
        check("post_rst_halt", 32'({ctl.state_dbg, ctl.Mem_WE}), 32'({HALTED, 1'b1}));
        ctl.Run = 1'b1;
        tick();
        check("post_rst_run", 32'(ctl.state_dbg), 32'(S18));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slc3_control.md
Name: slc3_control

Overview:
Instruction sequencing and decode unit for the SLC-3 CPU. A Moore FSM that drives every load, gate and mux-select input of the datapath. It also drives the memory enables and implements fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE. It sits directly upstream of the datapath and consumes IR fields and BEN from it.

Parameters:
MEM_WAIT, 2, number of memory wait cycles that hold the enable before MDR is loaded or a write completes (range 1..7).

Ports:
Clk  in  1  system clock; all state changes on the rising edge
Reset  in  1  asynchronous, active-low; state forced to HALTED while 0
Run  in  1  start execution from HALTED
Continue  in  1  release from PAUSE
Opcode  in  4  IR[15:12]
IR_5  in  1  IR[5], immediate/register select for ADD and AND
IR_11  in  1  IR[11], reserved (JSR/JSRR); treat as JSR only
BEN  in  1  branch-enable bit from the datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load strobes
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
SR2MUX  out  1  0 = sext(IR[4:0]), 1 = SR2 register
ADDR1MUX  out  1  0 = PC, 1 = SR1
DRMUX  out  1  0 = IR[11:9], 1 = R7
SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6]
MARMUX, MIO_EN  out  1 each  MARMUX: 0 = adder; MIO_EN: 1 = MDR loads from memory
PCMUX  out  2  0 = PC+1, 1 = bus, 2 = adder
ADDR2MUX  out  2  0 = zero, 1 = off6, 2 = off9, 3 = off11
ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT A, 11 = PASS A
Mem_OE, Mem_WE  out  1 each  active-low memory enables

Behaviour:
- Reset (async, Reset=0): state HALTED. All strobes, gates and selects are 0. Mem_OE = Mem_WE = 1. The wait counter is cleared. Reset during any state, including mid-memory-access, aborts immediately with no partial write strobe on the next cycle.
- Every output is a pure function of the current state plus IR_5 (Moore, registered state). The default for each output is its reset value.
- HALTED: stay while Run=0. Run=1 goes to S18.
- S18: GatePC, LD_MAR, PCMUX=0, LD_PC. Next is S33.
- S33: Mem_OE=0, MIO_EN=1. Hold for MEM_WAIT cycles using a wait counter, then LD_MDR in the final cycle. Next is S35.
- S35: GateMDR, LD_IR. Next is S32.
- S32: LD_BEN. Dispatch on Opcode:
  - 0001 to S01; 0101 to S05; 1001 to S09.
  - 0000 to S00; 1100 to S12; 0100 to S04.
  - 0110 to S06; 0111 to S07; 1101 to PAUSE1.
  - Any other opcode is a NOP and goes to S18.
- S01 and S05 (ADD/AND): SR1MUX=1, SR2MUX=~IR_5, ALUK=00 or 01, GateALU, DRMUX=0, LD_REG, LD_CC. Next is S18.
- S09 (NOT): SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC. Next is S18.
- S00 (BR): if BEN=1 go to S22, else S18.
- S22: ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC. Next is S18.
- S12 (JMP): SR1MUX=1, ALUK=11, GateALU, PCMUX=1, LD_PC. Next is S18.
- S04 (JSR): GatePC, DRMUX=1, LD_REG. Next is S21.
- S21: ADDR1MUX=0, ADDR2MUX=3, PCMUX=2, LD_PC. Next is S18.
- S06 and S07 (LDR/STR): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, MARMUX=0, GateMARMUX, LD_MAR. S06 goes to S25; S07 goes to S23.
- S25: same as S33. Next is S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC. Next is S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR. Next is S16.
- S16: Mem_WE=0 for MEM_WAIT cycles. Next is S18.
- PAUSE1: LD_LED. Stay while Continue=0; Continue=1 goes to PAUSE2.
- PAUSE2: stay while Continue=1; Continue=0 goes to S18. This prevents a held button from skipping multiple pauses.
- Wait counter: 3 bits. Loaded with MEM_WAIT-1 on entry to S33, S25 or S16, then decrements. Exit happens when it reaches 0.
- Run is sampled only in HALTED. Execution never returns to HALTED except via reset.
- Bus invariant: the four Gate* signals are mutually exclusive in every state. Mem_OE and Mem_WE are never low together.

Decomposition:
- Package slc3_pkg holds:
  - the state enum (typedef state_t);
  - opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LDR, OP_STR, OP_PAUSE);
  - ALUK, PCMUX and ADDR2MUX encoding constants, shared with the datapath.
- One natural sub-module, mem_wait_timer: a loadable down-counter with a done flag, reused by S33, S25 and S16.

Test Plan:
- Reset=0 asserted mid-S16 (Mem_WE=0) -> same cycle Mem_WE=1, all strobes 0; after release, state HALTED, and Run=0 holds it there.
- Run=1 with MEM_WAIT=2, Opcode=0001, IR_5=1 -> S18, S33, S33, S35, S32, S01. In S01: SR2MUX=0, GateALU=1, LD_REG=1, LD_CC=1. Back in S18 on cycle 7.
- Opcode=0000: BEN=1 -> S22 with PCMUX=2 and ADDR2MUX=2; BEN=0 -> S18 directly from S00.
- Opcode=0111 (STR) -> S07 (GateMARMUX=1, ADDR2MUX=1) -> S23 (MIO_EN=0, LD_MDR=1) -> S16 with Mem_WE=0 for exactly 2 cycles -> S18.
- Opcode=1101, Continue held 1 for 5 cycles, then 0 -> PAUSE1 exits on the first Continue=1; PAUSE2 holds all 5 cycles; S18 follows Continue=0. LD_LED=1 only in PAUSE1.
- Opcode=1111 (unsupported) -> S32 then S18 with no LD_REG, LD_PC or Mem_WE activity. Assertion across all runs: the Gate* signals are one-hot-or-zero every cycle.
